// File: rtl/mem_pkg.sv
// Shared types and constants for the memory issue scheduler.
package mem_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned TAG_W  = 6;
   localparam int unsigned ID_W   = 6;
   localparam int unsigned ADDR_W = 6;
   localparam int unsigned F3_W   = 3;

   localparam logic [F3_W-1:0] F3_LB  = 3'b000;
   localparam logic [F3_W-1:0] F3_LH  = 3'b001;
   localparam logic [F3_W-1:0] F3_LW  = 3'b010;
   localparam logic [F3_W-1:0] F3_LBU = 3'b100;
   localparam logic [F3_W-1:0] F3_LHU = 3'b101;
   localparam logic [F3_W-1:0] F3_SB  = 3'b000;
   localparam logic [F3_W-1:0] F3_SH  = 3'b001;
   localparam logic [F3_W-1:0] F3_SW  = 3'b010;

   typedef struct packed {
      logic              valid;
      logic              ld_st;
      logic [F3_W-1:0]   funct3;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   rs1_val;
      logic              rs1_rdy;
      logic [TAG_W-1:0]  rs1_tag;
      logic [XLEN-1:0]   sd_val;
      logic              sd_rdy;
      logic [TAG_W-1:0]  sd_tag;
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
   } mem_sched_entry_t;

   // Fields handed to the memory unit on issue.
   typedef struct packed {
      logic              ld_st;
      logic [F3_W-1:0]   funct3;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   rs1_val;
      logic [XLEN-1:0]   sd_val;
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
   } mem_issue_t;

   // Capture a broadcast result into any pending operand whose tag matches.
   function automatic mem_sched_entry_t snoop_cdb(input mem_sched_entry_t e,
                                                  input logic             hit,
                                                  input logic [TAG_W-1:0] tag,
                                                  input logic [XLEN-1:0]  val);
      mem_sched_entry_t r;
      r = e;
      if (hit && !e.rs1_rdy && (e.rs1_tag == tag)) begin
         r.rs1_val = val;
         r.rs1_rdy = 1'b1;
      end
      if (hit && !e.sd_rdy && (e.sd_tag == tag)) begin
         r.sd_val = val;
         r.sd_rdy = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mem_sched_entry.sv
// One scheduler queue slot: operand storage with CDB wake-up and dispatch bypass.
module mem_sched_entry
   import mem_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic                  clr_en,
   input  mem_sched_entry_t      wr_data,
   input  logic                  cdb_true,
   input  logic [TAG_W-1:0]      cdb_tag,
   input  logic [XLEN-1:0]       cdb_val,
   output logic                  elig_c,
   output mem_issue_t            payload_c
);

   mem_sched_entry_t ent_q, ent_d;

   always_comb begin
      ent_d = ent_q;
      if (ent_q.valid) begin
         ent_d = snoop_cdb(ent_q, cdb_true, cdb_tag, cdb_val);
      end
      if (clr_en) begin
         ent_d.valid = 1'b0;
      end
      if (wr_en) begin
         ent_d = snoop_cdb(wr_data, cdb_true, cdb_tag, cdb_val);
      end
      if (flush) begin
         ent_d.valid = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ent_q <= '0;
      end else begin
         ent_q <= ent_d;
      end
   end

   // Eligibility looks only at registered state.
   assign elig_c = ent_q.valid && ent_q.rs1_rdy && (!ent_q.ld_st || ent_q.sd_rdy);

   assign payload_c.ld_st   = ent_q.ld_st;
   assign payload_c.funct3  = ent_q.funct3;
   assign payload_c.imm     = ent_q.imm;
   assign payload_c.rs1_val = ent_q.rs1_val;
   assign payload_c.sd_val  = ent_q.sd_val;
   assign payload_c.id      = ent_q.id;
   assign payload_c.addr    = ent_q.addr;

endmodule

// File: rtl/mem_issue_sched.sv
// In-order memory op issue queue: circular FIFO, head-only issue to the memory unit.
module mem_issue_sched
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 disp_valid,
   output logic                 disp_ready,
   input  logic                 disp_ld_st,
   input  logic [F3_W-1:0]      disp_funct3,
   input  logic [XLEN-1:0]      disp_imm,
   input  logic [XLEN-1:0]      disp_rs1_val,
   input  logic                 disp_rs1_rdy,
   input  logic [TAG_W-1:0]     disp_rs1_tag,
   input  logic [XLEN-1:0]      disp_sd_val,
   input  logic                 disp_sd_rdy,
   input  logic [TAG_W-1:0]     disp_sd_tag,
   input  logic [ID_W-1:0]      disp_id,
   input  logic [ADDR_W-1:0]    disp_addr,
   input  logic                 cdb_true,
   input  logic [TAG_W-1:0]     cdb_tag,
   input  logic [XLEN-1:0]      cdb_val,
   input  logic                 flush,
   input  logic                 mem_stall,
   output logic                 new_inst,
   output logic [XLEN-1:0]      rs1,
   output logic [XLEN-1:0]      imm,
   output logic [XLEN-1:0]      store_data,
   output logic [F3_W-1:0]      funct3,
   output logic                 load_store,
   output logic [ID_W-1:0]      id,
   output logic [ADDR_W-1:0]    addr,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic             new_inst_q, new_inst_d;
   mem_issue_t       iss_q, iss_d;

   logic [DEPTH-1:0] ent_elig;
   mem_issue_t       ent_pl [DEPTH];
   logic [DEPTH-1:0] wr_sel, clr_sel;
   mem_sched_entry_t disp_ent;
   logic             do_disp, do_issue;

   assign disp_ready = (occ_q < CNT_W'(DEPTH)) && !flush;
   assign do_disp    = disp_valid && disp_ready;
   assign do_issue   = ent_elig[head_q] && !mem_stall && !flush;

   always_comb begin
      disp_ent         = '0;
      disp_ent.valid   = 1'b1;
      disp_ent.ld_st   = disp_ld_st;
      disp_ent.funct3  = disp_funct3;
      disp_ent.imm     = disp_imm;
      disp_ent.rs1_val = disp_rs1_val;
      disp_ent.rs1_rdy = disp_rs1_rdy;
      disp_ent.rs1_tag = disp_rs1_tag;
      disp_ent.sd_val  = disp_sd_val;
      disp_ent.sd_rdy  = disp_sd_rdy;
      disp_ent.sd_tag  = disp_sd_tag;
      disp_ent.id      = disp_id;
      disp_ent.addr    = disp_addr;
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      assign wr_sel[i]  = do_disp && (tail_q == PTR_W'(i));
      assign clr_sel[i] = do_issue && (head_q == PTR_W'(i));

      mem_sched_entry u_ent (
         .clk       (clk),
         .reset     (reset),
         .flush     (flush),
         .wr_en     (wr_sel[i]),
         .clr_en    (clr_sel[i]),
         .wr_data   (disp_ent),
         .cdb_true  (cdb_true),
         .cdb_tag   (cdb_tag),
         .cdb_val   (cdb_val),
         .elig_c    (ent_elig[i]),
         .payload_c (ent_pl[i])
      );
   end

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      occ_d      = occ_q;
      iss_d      = iss_q;
      new_inst_d = 1'b0;
      if (do_issue) begin
         iss_d      = ent_pl[head_q];
         new_inst_d = 1'b1;
         head_d     = head_q + PTR_W'(1);
      end
      if (do_disp) begin
         tail_d = tail_q + PTR_W'(1);
      end
      case ({do_disp, do_issue})
         2'b10:   occ_d = occ_q + CNT_W'(1);
         2'b01:   occ_d = occ_q - CNT_W'(1);
         default: occ_d = occ_q;
      endcase
      // Squash wins over everything; output data fields keep their last values.
      if (flush) begin
         head_d     = '0;
         tail_d     = '0;
         occ_d      = '0;
         new_inst_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         occ_q      <= '0;
         new_inst_q <= 1'b0;
         iss_q      <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         occ_q      <= occ_d;
         new_inst_q <= new_inst_d;
         iss_q      <= iss_d;
      end
   end

   assign new_inst   = new_inst_q;
   assign rs1        = iss_q.rs1_val;
   assign imm        = iss_q.imm;
   assign store_data = iss_q.sd_val;
   assign funct3     = iss_q.funct3;
   assign load_store = iss_q.ld_st;
   assign id         = iss_q.id;
   assign addr       = iss_q.addr;
   assign occupancy  = occ_q;

endmodule

// File: tb/tb_mem_issue_sched.sv
// Directed self-checking bench for mem_issue_sched.
module tb_mem_issue_sched;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        disp_valid, disp_ready, disp_ld_st;
   logic [2:0]  disp_funct3;
   logic [31:0] disp_imm, disp_rs1_val, disp_sd_val;
   logic        disp_rs1_rdy, disp_sd_rdy;
   logic [5:0]  disp_rs1_tag, disp_sd_tag, disp_id, disp_addr;
   logic        cdb_true;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_val;
   logic        flush, mem_stall;
   logic        new_inst, load_store;
   logic [31:0] rs1, imm, store_data;
   logic [2:0]  funct3;
   logic [5:0]  id, addr;
   logic [2:0]  occupancy;

   int n_chk = 0;
   int n_bad = 0;

   mem_issue_sched #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_ld_st(disp_ld_st), .disp_funct3(disp_funct3), .disp_imm(disp_imm),
      .disp_rs1_val(disp_rs1_val), .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_tag(disp_rs1_tag),
      .disp_sd_val(disp_sd_val), .disp_sd_rdy(disp_sd_rdy), .disp_sd_tag(disp_sd_tag),
      .disp_id(disp_id), .disp_addr(disp_addr),
      .cdb_true(cdb_true), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
      .flush(flush), .mem_stall(mem_stall),
      .new_inst(new_inst), .rs1(rs1), .imm(imm), .store_data(store_data),
      .funct3(funct3), .load_store(load_store), .id(id), .addr(addr),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      disp_valid = 1'b0; disp_ld_st = 1'b0; disp_funct3 = '0; disp_imm = '0;
      disp_rs1_val = '0; disp_rs1_rdy = 1'b0; disp_rs1_tag = '0;
      disp_sd_val = '0; disp_sd_rdy = 1'b0; disp_sd_tag = '0;
      disp_id = '0; disp_addr = '0;
      cdb_true = 1'b0; cdb_tag = '0; cdb_val = '0;
      flush = 1'b0;
   endtask

   task automatic set_disp(input logic st, input logic [31:0] rv, input logic rr,
                           input logic [5:0] rt, input logic [31:0] sv, input logic sr,
                           input logic [5:0] stg, input logic [31:0] iv, input logic [5:0] idv);
      disp_valid   = 1'b1;
      disp_ld_st   = st;
      disp_funct3  = st ? F3_SW : F3_LW;
      disp_imm     = iv;
      disp_rs1_val = rv;
      disp_rs1_rdy = rr;
      disp_rs1_tag = rt;
      disp_sd_val  = sv;
      disp_sd_rdy  = sr;
      disp_sd_tag  = stg;
      disp_id      = idv;
      disp_addr    = idv + 6'd1;
   endtask

   initial begin
      reset = 1'b0;
      mem_stall = 1'b0;
      idle();
      #12;
      chk("rst_occ", 32'(occupancy), 32'd0);
      chk("rst_new", 32'(new_inst), 32'd0);
      chk("rst_rs1", rs1, 32'd0);
      chk("rst_rdy", 32'(disp_ready), 32'd1);
      @(negedge clk);
      reset = 1'b1;

      // Single ready load: minimum latency.
      set_disp(1'b0, 32'h100, 1'b1, 6'd0, 32'h0, 1'b0, 6'd0, 32'h4, 6'd3);
      step();
      chk("t1_occ1", 32'(occupancy), 32'd1);
      chk("t1_new0", 32'(new_inst), 32'd0);
      idle();
      step();
      chk("t1_new1", 32'(new_inst), 32'd1);
      chk("t1_rs1",  rs1, 32'h100);
      chk("t1_imm",  imm, 32'h4);
      chk("t1_id",   32'(id), 32'd3);
      chk("t1_addr", 32'(addr), 32'd4);
      chk("t1_f3",   32'(funct3), 32'(F3_LW));
      chk("t1_occ0", 32'(occupancy), 32'd0);
      step();
      chk("t1_strobe", 32'(new_inst), 32'd0);
      chk("t1_hold", rs1, 32'h100);

      // Store waiting on data blocks a younger ready load.
      set_disp(1'b1, 32'h200, 1'b1, 6'd0, 32'h0, 1'b0, 6'd5, 32'h8, 6'd10);
      step();
      set_disp(1'b0, 32'h300, 1'b1, 6'd0, 32'h0, 1'b0, 6'd0, 32'hc, 6'd11);
      step();
      idle();
      chk("t2_occ2", 32'(occupancy), 32'd2);
      chk("t2_blk0", 32'(new_inst), 32'd0);
      step();
      chk("t2_blk1", 32'(new_inst), 32'd0);
      cdb_true = 1'b1; cdb_tag = 6'd5; cdb_val = 32'hDEADBEEF;
      step();
      idle();
      chk("t2_wake0", 32'(new_inst), 32'd0);
      step();
      chk("t2_st_new", 32'(new_inst), 32'd1);
      chk("t2_st_sd",  store_data, 32'hDEADBEEF);
      chk("t2_st_id",  32'(id), 32'd10);
      chk("t2_st_ls",  32'(load_store), 32'd1);
      step();
      chk("t2_ld_new", 32'(new_inst), 32'd1);
      chk("t2_ld_id",  32'(id), 32'd11);
      chk("t2_ld_rs1", rs1, 32'h300);
      step();
      chk("t2_done", 32'(new_inst), 32'd0);
      chk("t2_occ0", 32'(occupancy), 32'd0);

      // Fill under stall; pointers start at slot 3 so the queue wraps.
      mem_stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         set_disp(1'b0, 32'(16 * (20 + k)), 1'b1, 6'd0, 32'h0, 1'b0, 6'd0, 32'(k), 6'(20 + k));
         #1;
         chk($sformatf("t3_rdy%0d", k), 32'(disp_ready), (k < 4) ? 32'd1 : 32'd0);
         step();
         chk($sformatf("t3_occ%0d", k), 32'(occupancy), (k < 4) ? 32'(k + 1) : 32'd4);
         chk($sformatf("t3_stl%0d", k), 32'(new_inst), 32'd0);
      end
      idle();
      mem_stall = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("t3_new%0d", k), 32'(new_inst), 32'd1);
         chk($sformatf("t3_id%0d", k),  32'(id), 32'(20 + k));
         chk($sformatf("t3_rs%0d", k),  rs1, 32'(16 * (20 + k)));
         chk($sformatf("t3_oc%0d", k),  32'(occupancy), 32'(3 - k));
      end
      step();
      chk("t3_end", 32'(new_inst), 32'd0);

      // Dispatch-cycle CDB bypass on store data.
      set_disp(1'b1, 32'h400, 1'b1, 6'd0, 32'h0, 1'b0, 6'd7, 32'h10, 6'd30);
      cdb_true = 1'b1; cdb_tag = 6'd7; cdb_val = 32'h55;
      step();
      idle();
      step();
      chk("t4_new", 32'(new_inst), 32'd1);
      chk("t4_sd",  store_data, 32'h55);
      chk("t4_id",  32'(id), 32'd30);

      // Simultaneous dispatch and issue keeps occupancy.
      set_disp(1'b0, 32'h500, 1'b1, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd35);
      step();
      set_disp(1'b0, 32'h600, 1'b1, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd36);
      step();
      idle();
      chk("t5_new", 32'(new_inst), 32'd1);
      chk("t5_id",  32'(id), 32'd35);
      chk("t5_occ", 32'(occupancy), 32'd1);
      step();
      chk("t5_id2", 32'(id), 32'd36);
      chk("t5_occ0", 32'(occupancy), 32'd0);

      // Flush with a concurrent dispatch; nothing survives.
      mem_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_disp(1'b0, 32'h700, 1'b1, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'(40 + k));
         step();
      end
      chk("t6_occ3", 32'(occupancy), 32'd3);
      set_disp(1'b0, 32'h777, 1'b1, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd45);
      flush = 1'b1;
      mem_stall = 1'b0;
      #1;
      chk("t6_rdy", 32'(disp_ready), 32'd0);
      step();
      idle();
      chk("t6_occ0", 32'(occupancy), 32'd0);
      chk("t6_new0", 32'(new_inst), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("t6_quiet%0d", k), 32'(new_inst), 32'd0);
      end
      chk("t6_occ_end", 32'(occupancy), 32'd0);

      // Asynchronous reset while issuing, then a fresh load.
      set_disp(1'b0, 32'h800, 1'b1, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd50);
      step();
      set_disp(1'b0, 32'h810, 1'b1, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd51);
      step();
      idle();
      chk("t7_pre", 32'(new_inst), 32'd1);
      reset = 1'b0;
      #1;
      chk("t7_new", 32'(new_inst), 32'd0);
      chk("t7_rs1", rs1, 32'd0);
      chk("t7_id",  32'(id), 32'd0);
      chk("t7_addr", 32'(addr), 32'd0);
      chk("t7_occ", 32'(occupancy), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      set_disp(1'b0, 32'h900, 1'b1, 6'd0, 32'h0, 1'b0, 6'd0, 32'h20, 6'd60);
      step();
      idle();
      chk("t7_occ1", 32'(occupancy), 32'd1);
      step();
      chk("t7_fresh", 32'(new_inst), 32'd1);
      chk("t7_fid", 32'(id), 32'd60);
      chk("t7_frs", rs1, 32'h900);
      step();
      chk("t7_gone", 32'(new_inst), 32'd0);
      chk("t7_empty", 32'(occupancy), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
